// File: rtl/hart_sched_pkg.sv
// Shared hart scheduler types: per-hart state encoding, default sizes and the eligibility helper.
package hart_sched_pkg;

  localparam int HART_NUM     = 4;
  localparam int HART_ID_W    = 2;
  localparam int HART_ID_B    = HART_ID_W - 1;
  localparam int HART_STATE_W = 2;
  localparam int HART_STATE_B = HART_STATE_W - 1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    HART_IDLE   = 2'd0,
    HART_READY  = 2'd1,
    HART_WAIT   = 2'd2,
    HART_RESUME = 2'd3
  } hart_state_e;

  // A hart can be fetched only while it is runnable or waiting to be redirected.
  function automatic logic state_runnable(input hart_state_e st);
    return (st == HART_READY) || (st == HART_RESUME);
  endfunction

endpackage

// File: rtl/hart_sched_if.sv
// Request/issue bundle between the main controller, IF stage and the hart scheduler.
interface hart_sched_if #(
  parameter int HART_ID_W = 2,
  parameter int HART_NUM  = 4
);
  logic                   cache_miss;
  logic [HART_ID_W-1:0]   cm_hart_id;
  logic [31:0]            cm_addr;
  logic                   refill_done;
  logic [HART_ID_W-1:0]   refill_hart_id;
  logic                   start_en;
  logic [HART_ID_W-1:0]   start_hart_id;
  logic [31:0]            start_pc;
  logic                   kill_en;
  logic [HART_ID_W-1:0]   kill_hart_id;
  logic                   issue_valid;
  logic [HART_ID_W-1:0]   issue_id;
  logic                   resume_valid;
  logic [31:0]            resume_pc;
  logic                   hart_stall;
  logic [2*HART_NUM-1:0]  hart_state;
  logic                   all_idle;

  modport master (
    output cache_miss, cm_hart_id, cm_addr,
    output refill_done, refill_hart_id,
    output start_en, start_hart_id, start_pc,
    output kill_en, kill_hart_id,
    input  issue_valid, issue_id, resume_valid, resume_pc,
    input  hart_stall, hart_state, all_idle
  );

  modport slave (
    input  cache_miss, cm_hart_id, cm_addr,
    input  refill_done, refill_hart_id,
    input  start_en, start_hart_id, start_pc,
    input  kill_en, kill_hart_id,
    output issue_valid, issue_id, resume_valid, resume_pc,
    output hart_stall, hart_state, all_idle
  );
endinterface

// File: rtl/hart_sched_rr_arbiter.sv
// Combinational round-robin picker over the eligible-hart mask, starting after last_id.
// Optional HART_SCHED_PRIO_EN gives hart 0 fixed priority over the rotation.
module hart_rr_arbiter
  import hart_sched_pkg::*;
#(
  parameter int N = HART_NUM,
  parameter int W = HART_ID_W
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_id,
  output logic [W-1:0] grant_id,
  output logic         grant_valid
);

  logic [W-1:0] rr_id_s;
  logic [W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest eligible hart after last_id wins.
  always_comb begin
    rr_id_s = {W{1'b0}};
    idx_s   = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx_s   = last_id + W'(k + 1);
      rr_id_s = eligible[idx_s] ? idx_s : rr_id_s;
    end
  end

  assign grant_valid = |eligible;

`ifdef HART_SCHED_PRIO_EN
  assign grant_id = eligible[0] ? {W{1'b0}} : rr_id_s;
`else
  assign grant_id = rr_id_s;
`endif

endmodule

// File: rtl/hart_sched.sv
// Per-hart scheduler: parks harts on cache miss, wakes them on refill and selects the next hart for IF.
// Build option HART_SCHED_PRIO_EN (handled in hart_rr_arbiter) gives hart 0 fixed priority.
module hart_sched
  import hart_sched_pkg::*;
#(
  parameter int          HART_NUM  = 4,
  parameter int          HART_ID_W = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  hart_sched_if.slave bus
);

  hart_state_e           state_r    [HART_NUM];
  hart_state_e           state_nx_s [HART_NUM];
  logic [31:0]           pc_buf_r   [HART_NUM];
  logic [31:0]           pc_nx_s    [HART_NUM];
  logic [HART_NUM-1:0]   eligible_s;
  logic [HART_ID_W-1:0]  last_id_r;
  logic [HART_ID_W-1:0]  grant_id_s;
  logic                  grant_valid_s;
  logic                  grant_resume_s;
  logic                  all_idle_s;
  logic [2*HART_NUM-1:0] hart_state_s;

  logic                  issue_valid_r;
  logic [HART_ID_W-1:0]  issue_id_r;
  logic                  resume_valid_r;
  logic [31:0]           resume_pc_r;
  logic                  all_idle_r;

  // Harts hit by a kill or miss this cycle are withheld so a miss always beats selection.
  always_comb begin
    eligible_s = {HART_NUM{1'b0}};
    for (int h = 0; h < HART_NUM; h++) begin
      eligible_s[h] = state_runnable(state_r[h])
                    && !(bus.kill_en    && (bus.kill_hart_id == HART_ID_W'(h)))
                    && !(bus.cache_miss && (bus.cm_hart_id   == HART_ID_W'(h)));
    end
  end

  hart_rr_arbiter #(
    .N (HART_NUM),
    .W (HART_ID_W)
  ) u_arb (
    .eligible    (eligible_s),
    .last_id     (last_id_r),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  assign grant_resume_s = grant_valid_s && (state_r[grant_id_s] == HART_RESUME);

  // Per-hart next state in priority order: kill, miss, refill, start, issue of a resuming hart.
  always_comb begin
    for (int h = 0; h < HART_NUM; h++) begin
      state_nx_s[h] = state_r[h];
      pc_nx_s[h]    = pc_buf_r[h];
      if (bus.kill_en && (bus.kill_hart_id == HART_ID_W'(h))) begin
        state_nx_s[h] = HART_IDLE;
      end else if (bus.cache_miss && (bus.cm_hart_id == HART_ID_W'(h))
                   && (state_r[h] == HART_READY)) begin
        state_nx_s[h] = HART_WAIT;
        pc_nx_s[h]    = bus.cm_addr;
      end else if (bus.refill_done && (bus.refill_hart_id == HART_ID_W'(h))
                   && (state_r[h] == HART_WAIT)) begin
        state_nx_s[h] = HART_RESUME;
      end else if (bus.start_en && (bus.start_hart_id == HART_ID_W'(h))
                   && (state_r[h] == HART_IDLE)) begin
        state_nx_s[h] = HART_RESUME;
        pc_nx_s[h]    = bus.start_pc;
      end else if (grant_valid_s && (grant_id_s == HART_ID_W'(h))
                   && (state_r[h] == HART_RESUME)) begin
        state_nx_s[h] = HART_READY;
      end else begin
        state_nx_s[h] = state_r[h];
      end
    end
  end

  // all_idle reflects the post-update state so a final kill is seen the same cycle it lands.
  always_comb begin
    all_idle_s = 1'b1;
    for (int h = 0; h < HART_NUM; h++) begin
      all_idle_s = all_idle_s && (state_nx_s[h] == HART_IDLE);
    end
  end

  // Per-hart state and replay PC registers; hart 0 boots into RESUME at RESET_PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int h = 0; h < HART_NUM; h++) begin
        state_r[h]  <= (h == 0) ? HART_RESUME : HART_IDLE;
        pc_buf_r[h] <= (h == 0) ? RESET_PC : 32'h0;
      end
    end else begin
      for (int h = 0; h < HART_NUM; h++) begin
        state_r[h]  <= state_nx_s[h];
        pc_buf_r[h] <= pc_nx_s[h];
      end
    end
  end

  // Issue/resume output registers and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id_r      <= HART_ID_W'(HART_NUM - 1);
      issue_valid_r  <= 1'b0;
      issue_id_r     <= {HART_ID_W{1'b0}};
      resume_valid_r <= 1'b0;
      resume_pc_r    <= 32'h0;
      all_idle_r     <= 1'b0;
    end else begin
      issue_valid_r  <= grant_valid_s;
      resume_valid_r <= grant_resume_s;
      all_idle_r     <= all_idle_s;
      if (grant_valid_s) begin
        last_id_r  <= grant_id_s;
        issue_id_r <= grant_id_s;
      end else begin
        last_id_r  <= last_id_r;
        issue_id_r <= issue_id_r;
      end
      if (grant_resume_s) begin
        resume_pc_r <= pc_buf_r[grant_id_s];
      end else begin
        resume_pc_r <= resume_pc_r;
      end
    end
  end

  always_comb begin
    hart_state_s = {2*HART_NUM{1'b0}};
    for (int h = 0; h < HART_NUM; h++) begin
      hart_state_s[2*h +: 2] = state_r[h];
    end
  end

  assign bus.issue_valid  = issue_valid_r;
  assign bus.issue_id     = issue_id_r;
  assign bus.resume_valid = resume_valid_r;
  assign bus.resume_pc    = resume_pc_r;
  assign bus.hart_stall   = ~issue_valid_r;
  assign bus.hart_state   = hart_state_s;
  assign bus.all_idle     = all_idle_r;

endmodule

// File: tb/tb_hart_sched.sv
// Directed self-checking bench for hart_sched (4 harts, RESET_PC = 0).
module tb_hart_sched;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hart_sched_if #(.HART_ID_W(2), .HART_NUM(4)) bus ();

  hart_sched #(.HART_NUM(4), .HART_ID_W(2), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.cache_miss     = 1'b0;
    bus.cm_hart_id     = 2'd0;
    bus.cm_addr        = 32'h0;
    bus.refill_done    = 1'b0;
    bus.refill_hart_id = 2'd0;
    bus.start_en       = 1'b0;
    bus.start_hart_id  = 2'd0;
    bus.start_pc       = 32'h0;
    bus.kill_en        = 1'b0;
    bus.kill_hart_id   = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic miss(input logic [1:0] id, input logic [31:0] addr);
    bus.cache_miss = 1'b1; bus.cm_hart_id = id; bus.cm_addr = addr;
    tick();
  endtask

  task automatic refill(input logic [1:0] id);
    bus.refill_done = 1'b1; bus.refill_hart_id = id;
    tick();
  endtask

  task automatic start(input logic [1:0] id, input logic [31:0] pc);
    bus.start_en = 1'b1; bus.start_hart_id = id; bus.start_pc = pc;
    tick();
  endtask

  task automatic kill(input logic [1:0] id);
    bus.kill_en = 1'b1; bus.kill_hart_id = id;
    tick();
  endtask

  task automatic chk_issue(input string tag, input logic [1:0] id, input logic rv);
    chk({tag, "_iv"}, {31'd0, bus.issue_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, bus.issue_id}, {30'd0, id});
    chk({tag, "_rv"}, {31'd0, bus.resume_valid}, {31'd0, rv});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iv",    {31'd0, bus.issue_valid},  32'd0);
    chk("rst_id",    {30'd0, bus.issue_id},     32'd0);
    chk("rst_rv",    {31'd0, bus.resume_valid}, 32'd0);
    chk("rst_rpc",   bus.resume_pc,             32'h0);
    chk("rst_stall", {31'd0, bus.hart_stall},   32'd1);
    chk("rst_idle",  {31'd0, bus.all_idle},     32'd0);
    chk("rst_hs",    {24'd0, bus.hart_state},   32'h03);
    reset = 1'b1;

    tick();
    chk_issue("boot1", 2'd0, 1'b1);
    chk("boot1_rpc",   bus.resume_pc,           32'h0);
    chk("boot1_hs",    {24'd0, bus.hart_state}, 32'h01);
    chk("boot1_stall", {31'd0, bus.hart_stall}, 32'd0);
    tick();
    chk_issue("boot2", 2'd0, 1'b0);

`ifndef HART_SCHED_PRIO_EN
    miss(2'd0, 32'h100);
    chk("miss0_iv",    {31'd0, bus.issue_valid}, 32'd0);
    chk("miss0_stall", {31'd0, bus.hart_stall},  32'd1);
    chk("miss0_hs",    {24'd0, bus.hart_state},  32'h02);
    miss(2'd0, 32'h999);
    chk("miss_wait_hs",    {24'd0, bus.hart_state}, 32'h02);
    chk("miss_wait_stall", {31'd0, bus.hart_stall}, 32'd1);
    refill(2'd0);
    chk("refill0_hs", {24'd0, bus.hart_state},  32'h03);
    chk("refill0_iv", {31'd0, bus.issue_valid}, 32'd0);
    tick();
    chk_issue("replay0", 2'd0, 1'b1);
    chk("replay0_rpc", bus.resume_pc,           32'h100);
    chk("replay0_hs",  {24'd0, bus.hart_state}, 32'h01);

    start(2'd1, 32'h2000);
    chk_issue("start1", 2'd0, 1'b0);
    chk("start1_hs",  {24'd0, bus.hart_state}, 32'h0D);
    chk("start1_rpc", bus.resume_pc,           32'h100);
    tick();
    chk_issue("alt1", 2'd1, 1'b1);
    chk("alt1_rpc", bus.resume_pc, 32'h2000);
    chk("alt1_hs",  {24'd0, bus.hart_state}, 32'h05);
    tick(); chk_issue("alt2", 2'd0, 1'b0);
    tick(); chk_issue("alt3", 2'd1, 1'b0);
    tick(); chk_issue("alt4", 2'd0, 1'b0);

    miss(2'd1, 32'h300);
    chk_issue("mwin1", 2'd0, 1'b0);
    chk("mwin_hs", {24'd0, bus.hart_state}, 32'h09);
    tick(); chk_issue("mwin2", 2'd0, 1'b0);
    tick(); chk_issue("mwin3", 2'd0, 1'b0);
    refill(2'd1);
    chk_issue("mwin4", 2'd0, 1'b0);
    chk("mwin4_hs", {24'd0, bus.hart_state}, 32'h0D);
    tick();
    chk_issue("replay1", 2'd1, 1'b1);
    chk("replay1_rpc", bus.resume_pc, 32'h300);

    start(2'd0, 32'h7777);
    chk_issue("start_busy", 2'd0, 1'b0);
    chk("start_busy_hs", {24'd0, bus.hart_state}, 32'h05);
    start(2'd2, 32'h4000);
    chk_issue("start2", 2'd1, 1'b0);
    chk("start2_hs", {24'd0, bus.hart_state}, 32'h35);
    tick();
    chk_issue("run2", 2'd2, 1'b1);
    chk("run2_rpc", bus.resume_pc, 32'h4000);
    miss(2'd2, 32'h500);
    chk_issue("miss2", 2'd0, 1'b0);
    chk("miss2_hs", {24'd0, bus.hart_state}, 32'h25);
    kill(2'd2);
    chk_issue("kill2", 2'd1, 1'b0);
    chk("kill2_hs", {24'd0, bus.hart_state}, 32'h05);
    refill(2'd2);
    chk_issue("late_refill", 2'd0, 1'b0);
    chk("late_refill_hs", {24'd0, bus.hart_state}, 32'h05);
    kill(2'd0);
    chk_issue("kill0", 2'd1, 1'b0);
    chk("kill0_idle", {31'd0, bus.all_idle},   32'd0);
    chk("kill0_hs",   {24'd0, bus.hart_state}, 32'h04);
    kill(2'd1);
    chk("kill1_iv",    {31'd0, bus.issue_valid}, 32'd0);
    chk("kill1_stall", {31'd0, bus.hart_stall},  32'd1);
    chk("kill1_idle",  {31'd0, bus.all_idle},    32'd1);
    chk("kill1_hs",    {24'd0, bus.hart_state},  32'h00);
    refill(2'd3);
    chk("idle_refill_idle", {31'd0, bus.all_idle},    32'd1);
    chk("idle_refill_iv",   {31'd0, bus.issue_valid}, 32'd0);
`else
    start(2'd1, 32'h1000); chk_issue("p_st1", 2'd0, 1'b0);
    start(2'd2, 32'h2000); chk_issue("p_st2", 2'd0, 1'b0);
    start(2'd3, 32'h3000); chk_issue("p_st3", 2'd0, 1'b0);
    chk("p_hs", {24'd0, bus.hart_state}, 32'hFD);
    tick(); chk_issue("p_hold", 2'd0, 1'b0);
    miss(2'd0, 32'h100);
    chk_issue("p_rr1", 2'd1, 1'b1);
    chk("p_rr1_rpc", bus.resume_pc, 32'h1000);
    tick(); chk_issue("p_rr2", 2'd2, 1'b1);
    tick(); chk_issue("p_rr3", 2'd3, 1'b1);
    chk("p_rr3_hs", {24'd0, bus.hart_state}, 32'h56);
    refill(2'd0); chk_issue("p_ref", 2'd1, 1'b0);
    tick();
    chk_issue("p_back0", 2'd0, 1'b1);
    chk("p_back0_rpc", bus.resume_pc, 32'h100);
    tick(); chk_issue("p_fix1", 2'd0, 1'b0);
    tick(); chk_issue("p_fix2", 2'd0, 1'b0);
    miss(2'd0, 32'h200); chk_issue("p_m1", 2'd1, 1'b0);
    tick(); chk_issue("p_m2", 2'd2, 1'b0);
    tick(); chk_issue("p_m3", 2'd3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hart_sched.md
Name: hart_sched

Overview:
- Per-hart scheduler and issue selector for the multithreaded FMRT Mini Core.
- Consumes the cache-miss report from the main controller (cache_miss, cm_hart_id, cm_addr) and parks the missing hart.
- Wakes the hart on refill and replays it from the missed address.
- Selects the hart that IF fetches next (issue_id); asserts hart_stall when no hart is eligible.

Parameters:
HART_NUM, 4, number of hardware threads (power of two)
HART_ID_W, 2, log2(HART_NUM)
RESET_PC, 32'h0, boot PC loaded into hart 0 at reset

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-low reset
cache_miss  in  1  miss report, one-cycle pulse per miss
cm_hart_id  in  HART_ID_W  hart that missed
cm_addr  in  32  PC/address to replay from
refill_done  in  1  refill complete pulse
refill_hart_id  in  HART_ID_W  hart whose refill completed
start_en  in  1  start request for an idle hart
start_hart_id  in  HART_ID_W  hart to start
start_pc  in  32  first PC of started hart
kill_en  in  1  kill request
kill_hart_id  in  HART_ID_W  hart to kill
issue_valid  out  1  issue_id is valid this cycle
issue_id  out  HART_ID_W  hart selected for IF
resume_valid  out  1  IF must redirect issue_id to resume_pc
resume_pc  out  32  replay/start PC
hart_stall  out  1  no eligible hart (~issue_valid)
hart_state  out  2*HART_NUM  packed per-hart state, for debug/CSR
all_idle  out  1  every hart IDLE

Behaviour:
- Per-hart 2-bit state: IDLE=0, READY=1, WAIT=2, RESUME=3. Per-hart 32-bit pc_buf.
- Reset, asynchronous, active-low:
  - hart 0 = RESUME with pc_buf[0]=RESET_PC; all other harts IDLE; all pc_buf other than pc_buf[0] are 0.
  - issue_valid=0, issue_id=0, resume_valid=0, resume_pc=0, hart_stall=1, all_idle=0.
- State transitions on clk, in priority order per hart:
  1. kill_en and id match: any state -> IDLE.
  2. cache_miss and id match and state READY: -> WAIT; pc_buf <= cm_addr.
  3. refill_done and id match and state WAIT: -> RESUME.
  4. start_en and id match and state IDLE: -> RESUME; pc_buf <= start_pc.
  5. Hart selected this cycle and state RESUME: -> READY.
- Requests that do not match the required state are ignored. Examples: a miss on a WAIT hart, a refill on a READY hart, a start on a non-IDLE hart.
- Eligible harts are those in READY or RESUME, excluding any hart hit by kill or cache_miss in the same cycle. A miss therefore wins over selection.
- Selection is round-robin:
  - Search begins at last_id+1 and wraps modulo HART_NUM.
  - last_id updates only when issue_valid is set.
  - A single eligible hart is selected every cycle.
- Registered outputs, 1-cycle latency from the selection cycle:
  - issue_valid=|eligible; issue_id=selected hart.
  - resume_valid=1 iff the selected hart was RESUME; resume_pc=its pc_buf. Otherwise resume_pc holds its last value.
- hart_stall = ~issue_valid (combinational from the register).
- all_idle is registered: it is 1 iff every hart is IDLE after the update.
- Simultaneous miss and refill on different harts: both apply in the same cycle.
- Reset mid-operation discards all WAIT state. An outstanding refill_done that arrives later is ignored, because its hart is no longer in WAIT.

Optional Feature:
HART_SCHED_PRIO_EN
- Defined: hart 0 has fixed priority. If hart 0 is eligible it is always selected; otherwise the remaining harts are selected round-robin.
- Undefined: pure round-robin across all harts, as specified above.

Decomposition:
- Add to hart_ctrl.h:
  - state encodings HART_IDLE, HART_READY, HART_WAIT, HART_RESUME
  - HART_ID_W, HART_ID_B, HART_NUM, HART_STATE_B
- Use the existing ENABLE/DISABLE macros from common_defines.v.
- One sub-module: hart_rr_arbiter.
  - Inputs: eligible mask, last_id.
  - Outputs: grant id, grant valid.
  - Combinational, rotate-and-priority-encode; the prio macro is handled inside it.

Test Plan:
- Reset release, no other stimulus -> cycle 1: issue_valid=1, issue_id=0, resume_valid=1, resume_pc=RESET_PC. Cycle 2: resume_valid=0, issue_id=0.
- Hart 0 READY; cache_miss with cm_hart_id=0, cm_addr=32'h100 -> hart_state[0]=WAIT, hart_stall=1. Then refill_done with refill_hart_id=0 -> RESUME, then issue_id=0, resume_valid=1, resume_pc=32'h100.
- start_en with start_hart_id=1, start_pc=32'h2000 while hart 0 READY -> hart 1 resumes at 32'h2000, then issue_id alternates 0,1,0,1.
- Harts 0 and 1 READY; cache_miss on hart 1 in the cycle it would be selected -> issue_id=0 on consecutive cycles; hart 1 is never issued until its refill.
- Hart 2 in WAIT; kill_en with kill_hart_id=2, then refill_done for hart 2 -> hart 2 stays IDLE. all_idle=1 once harts 0 and 1 are also killed.
- With HART_SCHED_PRIO_EN, harts 0-3 READY -> issue_id=0 every cycle. Miss on hart 0 -> issue_id rotates 1,2,3.
